// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared types and constants for the 2-way cache controller
package cache_types_pkg;

    localparam int NUM_WAYS = 2;
    localparam int PERF_W   = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_t;

    typedef logic way_t;

    // One-hot per-way strobe for a single way index
    function automatic logic [NUM_WAYS-1:0] way_onehot(input way_t w);
        return w ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_perf_counters.sv
// rtl/cache_perf_counters.sv - wrapping hit/miss/writeback event counters
module cache_perf_counters
    import cache_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hit_evt,
    input  logic              i_miss_evt,
    input  logic              i_wb_evt,
    output logic [PERF_W-1:0] o_hit_count,
    output logic [PERF_W-1:0] o_miss_count,
    output logic [PERF_W-1:0] o_wb_count
);

    logic [PERF_W-1:0] r_hit_count;
    logic [PERF_W-1:0] r_miss_count;
    logic [PERF_W-1:0] r_wb_count;

    // Count each event once per cycle; counters wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (i_hit_evt)  r_hit_count  <= r_hit_count + 1'b1;
            if (i_miss_evt) r_miss_count <= r_miss_count + 1'b1;
            if (i_wb_evt)   r_wb_count   <= r_wb_count + 1'b1;
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
    assign o_wb_count   = r_wb_count;

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - sequencing FSM for the 2-way write-back cache (optional CACHE_PERF_EN counters)
module cache_control
    import cache_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] dirty,
    input  logic                lru,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    output logic                pmem_addr_sel,
    output logic                way_sel,
    output logic                data_src,
    output logic [NUM_WAYS-1:0] load_data,
    output logic [NUM_WAYS-1:0] load_tag,
    output logic [NUM_WAYS-1:0] load_valid,
    output logic [NUM_WAYS-1:0] load_dirty,
    output logic                dirty_in,
    output logic                load_lru,
    output logic                lru_in
`ifdef CACHE_PERF_EN
    ,
    output logic [PERF_W-1:0]   hit_count,
    output logic [PERF_W-1:0]   miss_count,
    output logic [PERF_W-1:0]   wb_count
`endif
);

    cache_state_t r_state;
    cache_state_t w_next;
    way_t         r_victim;

    logic w_req;
    logic w_is_hit;
    way_t w_hit_way;

    assign w_req     = mem_read | mem_write;
    assign w_is_hit  = |hit;
    assign w_hit_way = hit[1];   // hit==2'b11 resolves to way 1

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Victim is latched once on the miss decision and held for the whole miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_victim <= 1'b0;
        else if (r_state == CHECK && w_req && !w_is_hit)
            r_victim <= lru;
    end

    // Next-state logic; a CHECK without a live request just falls back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_req) w_next = CHECK;
            CHECK: begin
                if (!w_req || w_is_hit)          w_next = IDLE;
                else if (valid[lru] & dirty[lru]) w_next = WRITEBACK;
                else                              w_next = ALLOCATE;
            end
            WRITEBACK: if (pmem_resp) w_next = ALLOCATE;
            ALLOCATE:  if (pmem_resp) w_next = CHECK;
            default:   w_next = IDLE;
        endcase
    end

    // Output decode; everything idles low unless the state drives it
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        data_src      = 1'b0;
        load_data     = '0;
        load_tag      = '0;
        load_valid    = '0;
        load_dirty    = '0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        case (r_state)
            CHECK: begin
                if (w_req && w_is_hit) begin
                    mem_resp = 1'b1;
                    way_sel  = w_hit_way;
                    load_lru = 1'b1;
                    lru_in   = ~w_hit_way;
                    if (mem_write) begin
                        load_data  = way_onehot(w_hit_way);
                        load_dirty = way_onehot(w_hit_way);
                        dirty_in   = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = r_victim;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data  = way_onehot(r_victim);
                    load_tag   = way_onehot(r_victim);
                    load_valid = way_onehot(r_victim);
                    load_dirty = way_onehot(r_victim);
                    data_src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_EN
    logic r_refill;

    // Marks the CHECK that follows a fill so its hit is not counted as a fresh hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_refill <= 1'b0;
        else        r_refill <= (r_state == ALLOCATE) && pmem_resp;
    end

    cache_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hit_evt    ((r_state == CHECK) && w_req && w_is_hit && !r_refill),
        .i_miss_evt   ((r_state == CHECK) && w_req && !w_is_hit),
        .i_wb_evt     ((r_state == WRITEBACK) && pmem_resp),
        .o_hit_count  (hit_count),
        .o_miss_count (miss_count),
        .o_wb_count   (wb_count)
    );
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - self-checking bench for cache_control (checks counters when CACHE_PERF_EN is defined)
module tb_cache_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       mem_read, mem_write, pmem_resp, lru;
    logic [1:0] hit, valid, dirty;
    logic       mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_src;
    logic [1:0] load_data, load_tag, load_valid, load_dirty;
    logic       dirty_in, load_lru, lru_in;
`ifdef CACHE_PERF_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_control dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .valid(valid), .dirty(dirty), .lru(lru),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .data_src(data_src),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in)
`ifdef CACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    typedef struct packed {
        logic       rd, wr;
        logic [1:0] h, v, d;
        logic       l, presp;
    } in_t;

    typedef struct packed {
        logic       mresp, prd, pwr, asel, wsel, dsrc;
        logic [1:0] ldat, ltag, lval, ldty;
        logic       din, llru, lin;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } frame_t;

    int     n_vec = 0;
    int     n_bad = 0;
    int     exp_hits = 0, exp_miss = 0, exp_wb = 0;
    frame_t q[$];
    frame_t tbl[8];

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic in_t mk_in(input logic rd, wr, input logic [1:0] h, v, d, input logic l, presp);
        in_t r;
        r.rd = rd; r.wr = wr; r.h = h; r.v = v; r.d = d; r.l = l; r.presp = presp;
        return r;
    endfunction

    function automatic out_t mk_out(input logic mr, pr, pw, as, ws, ds,
                                    input logic [1:0] ld, lt, lv, ldy,
                                    input logic di, ll, li);
        out_t o;
        o.mresp = mr; o.prd = pr; o.pwr = pw; o.asel = as; o.wsel = ws; o.dsrc = ds;
        o.ldat = ld; o.ltag = lt; o.lval = lv; o.ldty = ldy;
        o.din = di; o.llru = ll; o.lin = li;
        return o;
    endfunction

    // Expected outputs of a CHECK cycle that hits way w
    function automatic out_t hit_out(input logic w, input logic is_wr);
        logic [1:0] s;
        s = is_wr ? oh(w) : 2'b00;
        return mk_out(1'b1, 1'b0, 1'b0, 1'b0, w, 1'b0, s, 2'b00, 2'b00, s, is_wr, 1'b1, ~w);
    endfunction

    function automatic out_t act_out();
        return mk_out(mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_src,
                      load_data, load_tag, load_valid, load_dirty, dirty_in, load_lru, lru_in);
    endfunction

    task automatic check_out(input string tag, input out_t exp);
        out_t a;
        a = act_out();
        n_vec++;
        if (a !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: outputs got %h expected %h", tag, $time, a, exp);
        end
    endtask

    task automatic cmp32(input string tag, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, a, e);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef CACHE_PERF_EN
        cmp32({tag, "_hit_count"},  hit_count,  exp_hits);
        cmp32({tag, "_miss_count"}, miss_count, exp_miss);
        cmp32({tag, "_wb_count"},   wb_count,   exp_wb);
`endif
    endtask

    // Drive one cycle of inputs just after the rising edge, check at the falling edge
    task automatic apply(input frame_t f, input string tag);
        {mem_read, mem_write, hit, valid, dirty, lru, pmem_resp} = f.i;
        @(negedge clk);
        check_out(tag, f.o);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input in_t i, input out_t o);
        frame_t f;
        f.i = i; f.o = o;
        q.push_back(f);
    endtask

    task automatic drain(input string tag);
        frame_t f;
        while (q.size() > 0) begin
            f = q.pop_front();
            apply(f, tag);
        end
    endtask

    task automatic do_reset();
        {mem_read, mem_write, hit, valid, dirty, lru, pmem_resp} = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check_out("reset", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_hits = 0; exp_miss = 0; exp_wb = 0;
        check_perf("reset");
    endtask

    // Transaction-level reference: expected cycle frames for one CPU request
    task automatic gen_txn(input logic wr, input logic [1:0] h, v, d, input logic l,
                           input int wbl, input int rdl, input logic abort);
        logic rd, vic, last, rq_rd, rq_wr;
        rd = ~wr;
        push(mk_in(rd, wr, h, v, d, l, 1'($urandom)), '0);
        if (h != 2'b00) begin
            push(mk_in(rd, wr, h, v, d, l, 1'($urandom)), hit_out(h[1], wr));
            exp_hits++;
            return;
        end
        push(mk_in(rd, wr, h, v, d, l, 1'($urandom)), '0);
        exp_miss++;
        vic = l;
        rq_rd = rd & ~abort;
        rq_wr = wr & ~abort;
        if (v[vic] & d[vic]) begin
            for (int k = 0; k < wbl; k++) begin
                last = (k == wbl - 1);
                push(mk_in(rd, wr, 2'b00, v, d, 1'($urandom), last),
                     mk_out(1'b0, 1'b0, 1'b1, 1'b1, vic, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
            end
            exp_wb++;
        end
        for (int k = 0; k < rdl; k++) begin
            last = (k == rdl - 1);
            if (last)
                push(mk_in(rq_rd, rq_wr, 2'b00, v, d, 1'($urandom), 1'b1),
                     mk_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, oh(vic), oh(vic), oh(vic), oh(vic), 1'b0, 1'b0, 1'b0));
            else
                push(mk_in(rq_rd, rq_wr, 2'b00, v, d, 1'($urandom), 1'b0),
                     mk_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        end
        push(mk_in(rq_rd, rq_wr, oh(vic), v | oh(vic), d, 1'($urandom), 1'($urandom)),
             abort ? out_t'('0) : hit_out(vic, wr));
    endtask

    initial begin
        frame_t f;
        logic [1:0] rh;

        do_reset();

        // Hit cases: {inputs, expected outputs} per cycle
        tbl[0].i = mk_in(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0); tbl[0].o = '0;
        tbl[1].i = mk_in(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        tbl[1].o = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        tbl[2].i = mk_in(1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b1, 1'b0); tbl[2].o = '0;
        tbl[3].i = mk_in(1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b1, 1'b1);
        tbl[3].o = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        tbl[4].i = mk_in(1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0); tbl[4].o = '0;
        tbl[5].i = mk_in(1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0);
        tbl[5].o = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        tbl[6].i = mk_in(1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0); tbl[6].o = '0;
        tbl[7].i = mk_in(1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        tbl[7].o = mk_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) apply(tbl[k], "hit_table");
        exp_hits += 4;
        check_perf("hit_table");

        // Clean read miss, fill latency 5, victim way 1
        gen_txn(1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 0, 5, 1'b0);
        drain("clean_miss");
        // Dirty write miss on way 0 followed immediately by a back-to-back read hit
        gen_txn(1'b1, 2'b00, 2'b11, 2'b01, 1'b0, 3, 4, 1'b0);
        gen_txn(1'b0, 2'b10, 2'b11, 2'b01, 1'b0, 0, 0, 1'b0);
        drain("dirty_miss");
        check_perf("dirty_miss");
        // Request withdrawn mid-miss: fill completes, no response
        gen_txn(1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 0, 3, 1'b1);
        gen_txn(1'b0, 2'b00, 2'b11, 2'b11, 1'b1, 2, 3, 1'b1);
        drain("abort_miss");

        // Async reset during ALLOCATE
        f.i = mk_in(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0); f.o = '0;
        apply(f, "rst_seq_idle");
        apply(f, "rst_seq_check");
        f.o = mk_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        apply(f, "rst_seq_alloc");
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", '0);
        mem_read = 1'b0;
        pmem_resp = 1'b1;
        @(negedge clk);
        check_out("rst_held", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_hits = 0; exp_miss = 0; exp_wb = 0;
        check_perf("rst_async");
        f.i = mk_in(1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 1'b1); f.o = '0;
        apply(f, "late_presp");
        apply(f, "late_presp");

        // Counter scenario: three hits and one clean miss
        do_reset();
        gen_txn(1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 0, 0, 1'b0);
        gen_txn(1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 0, 0, 1'b0);
        gen_txn(1'b0, 2'b01, 2'b11, 2'b00, 1'b1, 0, 0, 1'b0);
        gen_txn(1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 0, 4, 1'b0);
        drain("perf_seq");
        check_perf("perf_seq");

        // Randomized transactions with idle gaps
        for (int t = 0; t < 150; t++) begin
            rh = 2'($urandom);
            if ($urandom_range(1) == 1) rh = 2'b00;
            gen_txn(1'($urandom), rh, 2'($urandom), 2'($urandom), 1'($urandom),
                    $urandom_range(4, 1), $urandom_range(5, 1), ($urandom_range(15) == 0));
            for (int g = $urandom_range(2); g > 0; g--)
                push(mk_in(1'b0, 1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom)), '0);
            drain("random");
        end
        check_perf("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way set-associative, write-back, write-allocate cache.
- Drives load strobes, way selects and muxes on the tag/valid/dirty/LRU/data arrays, and the physical-memory handshake.
- Arrays read combinationally with same-cycle write bypass, so hit status is valid in the cycle a request is examined.
- Sits between the CPU-side memory port and the cache datapath.

## Interface
- No parameters: fixed 2 ways; index/tag widths live in the datapath only.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_read / mem_write  in  1  CPU request; held until mem_resp; never both high
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit  in  2  per-way tag match AND valid, from datapath
- valid, dirty  in  2  per-way bits for the addressed set
- lru  in  1  index of least-recently-used way for the addressed set
- pmem_read / pmem_write  out  1  line fill / line writeback request, held until pmem_resp
- pmem_resp  in  1  one-cycle memory completion
- pmem_addr_sel  out  1  0 = request line address, 1 = victim tag + index
- way_sel  out  1  way routed to CPU read data and writeback data
- data_src  out  1  0 = CPU write data with byte enables, 1 = full line from pmem
- load_data, load_tag, load_valid, load_dirty  out  2  per-way one-cycle write strobes
- dirty_in  out  1  value written with load_dirty
- load_lru, lru_in  out  1  LRU update strobe and value (written value = way to evict next)

## Operation
States: IDLE, CHECK, WRITEBACK, ALLOCATE.
- IDLE: mem_read|mem_write → CHECK. All outputs 0.
- CHECK, hit: way h = hit[1] ? 1 : 0; way_sel=h, mem_resp=1, load_lru=1, lru_in=~h.
  - Write hit additionally: load_data[h]=1, data_src=0, load_dirty[h]=1, dirty_in=1.
  - Next state IDLE.
- CHECK, miss: victim v = lru.
  - valid[v]&dirty[v] → WRITEBACK.
  - Otherwise → ALLOCATE.
  - No mem_resp on a miss.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=v. On pmem_resp → ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0. On pmem_resp, that cycle:
  - load_data[v], load_tag[v], load_valid[v], load_dirty[v] all =1.
  - dirty_in=0, data_src=1.
  - Next state CHECK; re-check hits through the array write bypass.
- Victim v is registered on CHECK→miss; it is not re-sampled during the miss.
- hit==2'b11 is illegal; way 1 is chosen.

## Timing
- Reset: state=IDLE; every output 0; perf counters 0. Async assertion mid-miss drops pmem_read/pmem_write immediately. Any pmem_resp arriving after reset is ignored.
- Hit latency: request visible in cycle 0, mem_resp in cycle 1.
- Clean-miss latency: 1 + pmem read latency + 1 cycles; the final CHECK asserts mem_resp.
- Dirty miss adds the pmem write latency.
- pmem_read and pmem_write are never high together. Both are held stable until pmem_resp.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- All strobes are single-cycle pulses.
- Request deasserted mid-miss (protocol violation): the fill completes and the FSM returns to IDLE from CHECK with no mem_resp.
- Back-to-back requests: a new request held in the cycle after mem_resp enters CHECK in the following cycle.

## Configuration
- CACHE_PERF_EN defined:
  - Adds outputs hit_count, miss_count, wb_count (32-bit each, wrapping).
  - hit_count increments on a CHECK hit that is not the re-check after a fill.
  - miss_count increments on CHECK→miss.
  - wb_count increments on pmem_resp in WRITEBACK.
- CACHE_PERF_EN undefined: the ports and counters do not exist; FSM behaviour is identical.

## Structure
- Shared package cache_types_pkg:
  - cache_state_t enum (IDLE, CHECK, WRITEBACK, ALLOCATE).
  - way_t (1 bit).
  - constants NUM_WAYS=2, PERF_W=32.
- Sub-module cache_perf_counters: the three counters, instantiated only under CACHE_PERF_EN.

## Test plan
- Read hit, way 0 (hit=01): mem_resp in cycle 1; load_lru=1, lru_in=1; no pmem activity.
- Write hit, way 1 (hit=10): same cycle as mem_resp, load_data=10, load_dirty=10, dirty_in=1, data_src=0, lru_in=0.
- Clean read miss (hit=00, lru=1, dirty=00), pmem_resp after 5 cycles:
  - pmem_read held 5 cycles, pmem_write never high.
  - Fill strobes on way 1 with dirty_in=0.
  - mem_resp one cycle after pmem_resp.
- Dirty write miss (lru=0, valid=11, dirty=01):
  - pmem_write with pmem_addr_sel=1, way_sel=0 until pmem_resp, then pmem_read.
  - Fill on way 0, then write hit sets dirty.
  - wb_count=1 when CACHE_PERF_EN is defined.
- rst_n pulled low during ALLOCATE:
  - All outputs 0 asynchronously; state IDLE.
  - A late pmem_resp produces no strobes.
- CACHE_PERF_EN defined, 3 hits + 1 clean miss: hit_count=3 (the re-check after the fill is not counted), miss_count=1, wb_count=0.
